// File: rtl/ram_pair_reader_pkg.sv
// Shared constants and FSM encoding for the RAM pair read path.
package ram_pair_reader_pkg;

  localparam int unsigned DefAddrW = 8;
  localparam int unsigned DefDataW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StFinish
  } state_e;

endpackage

// File: rtl/ram_pair_reader_pair_capture.sv
// Output stage: registers RAM read pairs and keeps the running total of earlier pairs.
module ram_pair_reader_pair_capture
  import ram_pair_reader_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              cap_i,
  input  logic [DATA_W-1:0] dout1_i,
  input  logic [DATA_W-1:0] dout2_i,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [DATA_W-1:0] sum_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data1_q, data1_d;
  logic [DATA_W-1:0] data2_q, data2_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              valid_q, valid_d;

  always_comb begin
    data1_d = data1_q;
    data2_d = data2_q;
    sum_d   = sum_q;
    acc_d   = acc_q;
    valid_d = 1'b0;
    if (clr_i) begin
      sum_d = '0;
      acc_d = '0;
    end else if (cap_i) begin
      data1_d = dout1_i;
      data2_d = dout2_i;
      // sum_o carries the total before this pair; the downstream adder completes it.
      sum_d   = acc_q;
      acc_d   = acc_q + dout1_i + dout2_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data1_q <= '0;
      data2_q <= '0;
      sum_q   <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data1_q <= data1_d;
      data2_q <= data2_d;
      sum_q   <= sum_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
    end
  end

  assign data1_o = data1_q;
  assign data2_o = data2_q;
  assign sum_o   = sum_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/ram_pair_reader.sv
// Read sequencer: walks a block of RAM words two per cycle and feeds the final-sum adder.
module ram_pair_reader
  import ram_pair_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_pairs,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  input  logic [DATA_W-1:0] ram_dout1,
  input  logic [DATA_W-1:0] ram_dout2,
  output logic [DATA_W-1:0] data1_from_ram,
  output logic [DATA_W-1:0] data2_from_ram,
  output logic [DATA_W-1:0] sum_0,
  output logic              pair_valid
);

  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_en_q;
  logic              rd_en_dly_q;
  logic [ADDR_W-1:0] addr1_q;
  logic [ADDR_W-1:0] addr2_q;
  logic [ADDR_W-1:0] left_q;
  logic              accept;

  assign accept = (state_q == StIdle) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_en_dly_q <= 1'b0;
      addr1_q     <= '0;
      addr2_q     <= '0;
      left_q      <= '0;
    end else begin
      rd_en_dly_q <= rd_en_q;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (num_pairs != '0) begin
              state_q <= StRead;
              busy_q  <= 1'b1;
              rd_en_q <= 1'b1;
              addr1_q <= base_addr;
              addr2_q <= base_addr + ADDR_W'(1);
              left_q  <= num_pairs - ADDR_W'(1);
            end else begin
              state_q <= StFinish;
              done_q  <= 1'b1;
            end
          end
        end
        StRead: begin
          if (left_q == '0) begin
            state_q <= StDrain;
            rd_en_q <= 1'b0;
          end else begin
            addr1_q <= addr1_q + ADDR_W'(2);
            addr2_q <= addr2_q + ADDR_W'(2);
            left_q  <= left_q - ADDR_W'(1);
          end
        end
        StDrain: begin
          // Once the delayed enable drops, the last pair is on the outputs this cycle.
          if (!rd_en_dly_q) begin
            state_q <= StFinish;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StFinish: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  ram_pair_reader_pair_capture #(
    .DATA_W(DATA_W)
  ) u_pair_capture (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (accept),
    .cap_i  (rd_en_dly_q),
    .dout1_i(ram_dout1),
    .dout2_i(ram_dout2),
    .data1_o(data1_from_ram),
    .data2_o(data2_from_ram),
    .sum_o  (sum_0),
    .valid_o(pair_valid)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_en    = rd_en_q;
  assign rd_addr1 = addr1_q;
  assign rd_addr2 = addr2_q;

endmodule

// File: tb/tb_ram_pair_reader.sv
// Self-checking bench for ram_pair_reader with a RAM and final-sum adder around it.
module tb_ram_pair_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [7:0]  num_pairs;
  logic        busy;
  logic        done;
  logic        rd_en;
  logic [7:0]  rd_addr1;
  logic [7:0]  rd_addr2;
  logic [31:0] ram_dout1;
  logic [31:0] ram_dout2;
  logic [31:0] data1_from_ram;
  logic [31:0] data2_from_ram;
  logic [31:0] sum_0;
  logic        pair_valid;

  logic [31:0] mem [256];
  logic [31:0] final_sum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_pair_reader #(
    .ADDR_W(8),
    .DATA_W(32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base_addr     (base_addr),
    .num_pairs     (num_pairs),
    .busy          (busy),
    .done          (done),
    .rd_en         (rd_en),
    .rd_addr1      (rd_addr1),
    .rd_addr2      (rd_addr2),
    .ram_dout1     (ram_dout1),
    .ram_dout2     (ram_dout2),
    .data1_from_ram(data1_from_ram),
    .data2_from_ram(data2_from_ram),
    .sum_0         (sum_0),
    .pair_valid    (pair_valid)
  );

  // Synchronous-read dual-port RAM and registered final-sum adder.
  always @(posedge clk) begin
    if (rd_en) begin
      ram_dout1 <= mem[rd_addr1];
      ram_dout2 <= mem[rd_addr2];
    end
    if (rst) final_sum <= 32'h0;
    else if (pair_valid) final_sum <= data1_from_ram + data2_from_ram + sum_0;
  end

  function automatic logic [31:0] word_at(input logic [7:0] base, input int off);
    logic [7:0] a;
    a = base + 8'(off);
    return mem[a];
  endfunction

  // Sum of pairs 0..k-1 of the block, modulo 2^32.
  function automatic logic [31:0] sum_before(input logic [7:0] base, input int k);
    logic [31:0] s;
    s = 32'h0;
    for (int j = 0; j < k; j++) s = s + word_at(base, 2 * j) + word_at(base, 2 * j + 1);
    return s;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
  endtask

  // Runs one block from a start in cycle 0; optional start-while-busy and reset cycles (0 = none).
  task automatic test_run(input string name, input logic [7:0] base, input int n,
                          input int busy_cyc, input int rst_cyc);
    logic        e_rd, e_pv, e_busy, e_done, hit_rst;
    logic [7:0]  e_a1;
    logic [31:0] e_d1, e_d2, e_s0;
    int          k;
    @(negedge clk);
    base_addr = base;
    num_pairs = 8'(n);
    start     = 1'b1;
    for (int c = 1; c <= n + 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b0;
      if (c == busy_cyc) begin
        start     = 1'b1;
        base_addr = base + 8'h40;
        num_pairs = 8'(n + 3);
      end
      hit_rst = (rst_cyc > 0) && (c > rst_cyc);
      if (c == rst_cyc) rst = 1'b1;
      e_rd   = !hit_rst && (c >= 1) && (c <= n);
      e_pv   = !hit_rst && (c >= 3) && (c <= n + 2);
      e_busy = !hit_rst && (c >= 1) && (c <= n + 2);
      e_done = !hit_rst && (c == n + 3);
      k      = (c <= n + 2) ? c - 3 : n - 1;
      e_a1   = base + 8'(2 * (c - 1));
      e_d1   = hit_rst ? 32'h0 : word_at(base, 2 * k);
      e_d2   = hit_rst ? 32'h0 : word_at(base, 2 * k + 1);
      e_s0   = (hit_rst || c < 3) ? 32'h0 : sum_before(base, k);
      total++;
      if (rd_en !== e_rd) begin
        bad++;
        $display("FAIL %s rd_en c=%0d got=%b want=%b", name, c, rd_en, e_rd);
      end
      if (e_rd) begin
        total++;
        if (rd_addr1 !== e_a1 || rd_addr2 !== e_a1 + 8'd1) begin
          bad++;
          $display("FAIL %s addr c=%0d got=%h/%h want=%h/%h", name, c, rd_addr1, rd_addr2,
                   e_a1, e_a1 + 8'd1);
        end
      end
      total++;
      if (pair_valid !== e_pv) begin
        bad++;
        $display("FAIL %s pair_valid c=%0d got=%b want=%b", name, c, pair_valid, e_pv);
      end
      total++;
      if (busy !== e_busy || done !== e_done) begin
        bad++;
        $display("FAIL %s busy/done c=%0d got=%b/%b want=%b/%b", name, c, busy, done,
                 e_busy, e_done);
      end
      if (e_pv || hit_rst || c > n + 2) begin
        total++;
        if (data1_from_ram !== e_d1 || data2_from_ram !== e_d2) begin
          bad++;
          $display("FAIL %s data c=%0d got=%h/%h want=%h/%h", name, c, data1_from_ram,
                   data2_from_ram, e_d1, e_d2);
        end
      end
      total++;
      if (sum_0 !== e_s0) begin
        bad++;
        $display("FAIL %s sum_0 c=%0d got=%h want=%h", name, c, sum_0, e_s0);
      end
      if (e_done) begin
        total++;
        if (final_sum !== sum_before(base, n)) begin
          bad++;
          $display("FAIL %s final_sum got=%h want=%h", name, final_sum, sum_before(base, n));
        end
      end
    end
    rst   = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    base_addr = 8'h0;
    num_pairs = 8'h0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, rd_en, pair_valid} !== 4'b0 || rd_addr1 !== 8'h0 || rd_addr2 !== 8'h0 ||
        data1_from_ram !== 32'h0 || data2_from_ram !== 32'h0 || sum_0 !== 32'h0) begin
      bad++;
      $display("FAIL reset outputs got b=%b d=%b r=%b v=%b s=%h want all zero", busy, done,
               rd_en, pair_valid, sum_0);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) mem[i] = 32'(i + 1);
    test_run("basic", 8'h00, 2, 0, 0);
    total++;
    if (final_sum !== 32'd10) begin
      bad++;
      $display("FAIL basic adder got=%0d want=10", final_sum);
    end
  endtask

  task automatic test_zero();
    @(negedge clk);
    base_addr = 8'h10;
    num_pairs = 8'h0;
    start     = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      total++;
      if (rd_en !== 1'b0 || pair_valid !== 1'b0 || busy !== 1'b0 || sum_0 !== 32'h0) begin
        bad++;
        $display("FAIL zero idle c=%0d got rd=%b v=%b b=%b s=%h want 0", c, rd_en, pair_valid,
                 busy, sum_0);
      end
      total++;
      if (done !== (c == 1)) begin
        bad++;
        $display("FAIL zero done c=%0d got=%b want=%b", c, done, c == 1);
      end
    end
  endtask

  task automatic test_wrap();
    fill_random();
    test_run("wrap", 8'hFE, 2, 0, 0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 256; i++) mem[i] = 32'hFFFF_FFFF;
    test_run("overflow", 8'h20, 2, 0, 0);
    total++;
    if (final_sum !== 32'hFFFF_FFFC || sum_0 !== 32'hFFFF_FFFE) begin
      bad++;
      $display("FAIL overflow got final=%h sum_0=%h want FFFFFFFC/FFFFFFFE", final_sum, sum_0);
    end
  endtask

  task automatic test_start_busy();
    for (int i = 0; i < 4; i++) mem[i] = 32'(i + 1);
    test_run("start_busy", 8'h00, 2, 2, 0);
  endtask

  task automatic test_reset_mid();
    fill_random();
    test_run("reset_mid", 8'h30, 4, 0, 3);
    for (int i = 0; i < 4; i++) mem[i] = 32'(i + 1);
    test_run("after_reset", 8'h00, 2, 0, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      fill_random();
      test_run("random", 8'($urandom), int'($urandom_range(1, 12)), 0, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    ram_dout1 = 32'h0;
    ram_dout2 = 32'h0;
    test_reset();
    test_basic();
    test_zero();
    test_wrap();
    test_overflow();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_pair_reader.md
# ram_pair_reader

Read sequencer that walks a block of words in the dual-port data RAM and feeds them, two per cycle, to the final-sum adder. Per cycle it drives both RAM read ports, realigns the synchronous-read RAM outputs into registered `data1_from_ram` / `data2_from_ram` pairs, and maintains `sum_0`, the running total of all previously delivered pairs. With this alignment, the adder's registered result after the last pair equals the sum of the whole block, modulo 2^DATA_W.

## Interface
- `ADDR_W`, default 8: RAM address width.
- `DATA_W`, default 32: word width. Must match the final-sum adder.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request, honoured only in IDLE.
- `base_addr`  in  ADDR_W  first word address, sampled on an accepted `start`.
- `num_pairs`  in  ADDR_W  number of word pairs to read, sampled on an accepted `start`.
- `busy`  out  1  high from the cycle after accept until the last pair is delivered.
- `done`  out  1  one-cycle completion pulse.
- `rd_en`  out  1  RAM read enable, both ports.
- `rd_addr1`  out  ADDR_W  port-1 address (even offset).
- `rd_addr2`  out  ADDR_W  port-2 address (odd offset).
- `ram_dout1`  in  DATA_W  port-1 read data, valid one cycle after `rd_en`.
- `ram_dout2`  in  DATA_W  port-2 read data, valid one cycle after `rd_en`.
- `data1_from_ram`  out  DATA_W  registered pair word 1.
- `data2_from_ram`  out  DATA_W  registered pair word 2.
- `sum_0`  out  DATA_W  registered sum of all earlier pairs in this run.
- `pair_valid`  out  1  high while the `data*` and `sum_0` outputs hold a fresh pair.

## Operation
- The FSM has four states: IDLE, READ, DRAIN and FINISH.
- **IDLE:**
  - `start` with `num_pairs`>0 latches `base_addr`/`num_pairs`, clears the accumulator to 0 and goes to READ.
  - `start` with `num_pairs`=0 goes to FINISH. No reads are issued and `sum_0` is cleared to 0.
- **READ:**
  - `rd_en`=1.
  - For pair index k: `rd_addr1`=base+2k and `rd_addr2`=base+2k+1, both modulo 2^ADDR_W (addresses wrap silently).
  - After pair N-1 is issued, go to DRAIN.
- **DRAIN:**
  - `rd_en`=0.
  - Wait until the last pair has been presented, then go to FINISH.
- **FINISH:** `done`=1 for one cycle, then return to IDLE.
- **Output stage:**
  - One cycle after a read, the output stage registers `ram_dout1`/`ram_dout2` into `data1_from_ram`/`data2_from_ram` and asserts `pair_valid`.
  - In the same update it loads `sum_0` with the accumulator value from before this pair.
  - The accumulator then adds `ram_dout1`+`ram_dout2`.
- **Arithmetic:** all sums are DATA_W bits and wrap modulo 2^DATA_W. Carries are discarded.
- **Hold behaviour:** `data*` and `sum_0` hold their values after the run ends, until the next accepted `start` or `rst`.
- **Ignored `start`:** a `start` seen outside IDLE has no effect, and no new inputs are sampled.
- **`rst`:** at any time, including mid-run, it forces IDLE on the next edge.
  - The FSM drops the run in progress with no `done` pulse.
  - All outputs and the accumulator go to 0: `busy`, `done`, `rd_en`, `pair_valid`, `rd_addr*`, `data*`, `sum_0`.

## Timing
- Cycle numbering: `start` is accepted in cycle 0.
- `rd_en` is high in cycles 1..N.
- RAM data is valid in cycles 2..N+1.
- `pair_valid` is high in cycles 3..N+2, one pair per cycle with no gaps.
- `busy` is high in cycles 1..N+2.
- `done` is high in cycle N+3, with `busy`=0.
- A new `start` is accepted from cycle N+4.
- The adder's `final_sum` for the last pair is visible in cycle N+3, coincident with `done`.
- When `num_pairs`=0: `busy` stays 0 and `done` is high in cycle 1.
- Throughput: 2 words per cycle. The block adds no backpressure; the RAM and adder always accept.

## Structure
- **Shared package:** FSM state encoding (IDLE/READ/DRAIN/FINISH) and default `ADDR_W`/`DATA_W` constants, reused by the RAM writer and the adder wrapper.
- **Sub-module `pair_capture`:** the output stage, containing the data registers, `pair_valid` and the `sum_0`/accumulator logic. It is driven by a delayed `rd_en`.
- **Top level:** holds the FSM, address counter and pair counter.

## Test plan
- **Basic run:** RAM[0..3]=1,2,3,4; start, base=0, N=2.
  - Pairs (1,2) with `sum_0`=0 in cycle 3.
  - Pairs (3,4) with `sum_0`=3 in cycle 4.
  - `done` in cycle 5, and the adder result is 10.
- **Zero-length run:** `num_pairs`=0.
  - `done` in cycle 1.
  - `rd_en` and `pair_valid` never assert, and `sum_0`=0.
- **Address wrap:** base=0xFE, N=2.
  - Addresses are (0xFE,0xFF) then (0x00,0x01).
- **Data overflow:** RAM words all 0xFFFF_FFFF, N=2.
  - `sum_0` of the second pair is 0xFFFF_FFFE.
  - The adder final result is 0xFFFF_FFFC.
- **Start while busy:** assert `start` in cycle 2 with different base/N.
  - It is ignored, and the run completes exactly as in the basic run.
- **Reset mid-run:** N=4, `rst` in cycle 3.
  - All outputs are 0 from cycle 4 and there is no `done` pulse.
  - A fresh `start` afterwards behaves as the basic run.
